// File: rtl/radix2_ifft4_seq.sv
// Sequential 4-point unscaled inverse DFT: loads four bins, runs two radix-2
// butterfly stages, then streams 4*x[n] out in natural order with backpressure.
module radix2_ifft4_seq (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [3:0] in_re,
  input  logic signed [3:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [5:0] out_re,
  output logic signed [5:0] out_im,
  output logic [1:0]        out_idx,
  output logic              out_last
);

  typedef enum logic [1:0] {StLoad, StStg1, StStg2, StOut} state_e;

  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;

  logic signed [3:0] xr_q [4];
  logic signed [3:0] xi_q [4];
  logic signed [5:0] ar_q [4];
  logic signed [5:0] ai_q [4];
  logic signed [5:0] yr_q [4];
  logic signed [5:0] yi_q [4];

  logic signed [5:0] xr_e [4];
  logic signed [5:0] xi_e [4];
  logic signed [5:0] ar_d [4];
  logic signed [5:0] ai_d [4];
  logic signed [5:0] yr_d [4];
  logic signed [5:0] yi_d [4];

  // Sign-extend stored bins so every butterfly sum is exact at 6 bits.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      xr_e[k] = {{2{xr_q[k][3]}}, xr_q[k]};
      xi_e[k] = {{2{xi_q[k][3]}}, xi_q[k]};
    end
  end

  // Stage 1: a3 = +j * (X1 - X3).
  always_comb begin
    ar_d[0] = xr_e[0] + xr_e[2];
    ai_d[0] = xi_e[0] + xi_e[2];
    ar_d[1] = xr_e[0] - xr_e[2];
    ai_d[1] = xi_e[0] - xi_e[2];
    ar_d[2] = xr_e[1] + xr_e[3];
    ai_d[2] = xi_e[1] + xi_e[3];
    ar_d[3] = xi_e[3] - xi_e[1];
    ai_d[3] = xr_e[1] - xr_e[3];
  end

  always_comb begin
    yr_d[0] = ar_q[0] + ar_q[2];
    yi_d[0] = ai_q[0] + ai_q[2];
    yr_d[1] = ar_q[1] + ar_q[3];
    yi_d[1] = ai_q[1] + ai_q[3];
    yr_d[2] = ar_q[0] - ar_q[2];
    yi_d[2] = ai_q[0] - ai_q[2];
    yr_d[3] = ar_q[1] - ar_q[3];
    yi_d[3] = ai_q[1] - ai_q[3];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = StStg1;
        end
      end
      StStg1: state_d = StStg2;
      StStg2: begin
        state_d = StOut;
        idx_d   = 2'd0;
      end
      StOut: begin
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
      cnt_q   <= 2'd0;
      idx_q   <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        xr_q[k] <= '0;
        xi_q[k] <= '0;
        ar_q[k] <= '0;
        ai_q[k] <= '0;
        yr_q[k] <= '0;
        yi_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (state_q == StLoad && in_valid) begin
        xr_q[cnt_q] <= in_re;
        xi_q[cnt_q] <= in_im;
      end
      if (state_q == StStg1) begin
        for (int k = 0; k < 4; k++) begin
          ar_q[k] <= ar_d[k];
          ai_q[k] <= ai_d[k];
        end
      end
      if (state_q == StStg2) begin
        for (int k = 0; k < 4; k++) begin
          yr_q[k] <= yr_d[k];
          yi_q[k] <= yi_d[k];
        end
      end
    end
  end

  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StOut);
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == 2'd3);
  assign out_re    = yr_q[idx_q];
  assign out_im    = yi_q[idx_q];

endmodule

// File: tb/tb_radix2_ifft4_seq.sv
// Randomized bench for radix2_ifft4_seq against a direct-summation IDFT model.
module tb_radix2_ifft4_seq;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [3:0] in_re;
  logic signed [3:0] in_im;
  logic              out_valid;
  logic              out_ready;
  logic signed [5:0] out_re;
  logic signed [5:0] out_im;
  logic [1:0]        out_idx;
  logic              out_last;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  radix2_ifft4_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  // 4*x[n] = sum_k X[k] * j^(n*k)
  function automatic void ref_idft(input int re[4], input int im[4],
                                   output int yr[4], output int yi[4]);
    for (int n = 0; n < 4; n++) begin
      yr[n] = 0;
      yi[n] = 0;
      for (int k = 0; k < 4; k++) begin
        case ((n * k) % 4)
          0: begin yr[n] += re[k]; yi[n] += im[k]; end
          1: begin yr[n] -= im[k]; yi[n] += re[k]; end
          2: begin yr[n] -= re[k]; yi[n] -= im[k]; end
          default: begin yr[n] += im[k]; yi[n] -= re[k]; end
        endcase
      end
    end
  endfunction

  // Pushes one frame and checks every output; stall_n forces 5 held cycles at that index.
  task automatic run_frame(input int re[4], input int im[4], input int vprob, input int rprob,
                           input int stall_n, input string tag);
    int yr[4];
    int yi[4];
    int k, edges, n, stalls, guard;
    logic [16:0] got, exp;
    ref_idft(re, im, yr, yi);
    k = 0;
    guard = 0;
    while (k < 4) begin
      in_valid = (int'($urandom_range(99)) < vprob) || (guard > 20);
      in_re = in_valid ? 4'(re[k]) : 4'($urandom);
      in_im = in_valid ? 4'(im[k]) : 4'($urandom);
      out_ready = 1'($urandom_range(1));
      nchk++;
      if ({in_ready, out_valid} !== 2'b10) begin
        nerr++;
        $display("FAIL %s load k=%0d: in_ready/out_valid got %b need 10", tag, k,
                 {in_ready, out_valid});
      end
      @(negedge clk);
      if (in_valid) begin k++; guard = 0; end else guard++;
    end
    edges = 1;
    while (out_valid !== 1'b1 && edges < 8) begin
      in_valid = 1'($urandom_range(1));
      in_re = 4'($urandom);
      in_im = 4'($urandom);
      nchk++;
      if (in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL %s compute in_ready got %b need 0", tag, in_ready);
      end
      @(negedge clk);
      edges++;
    end
    nchk++;
    if (out_valid !== 1'b1 || edges != 3) begin
      nerr++;
      $display("FAIL %s latency: out_valid=%b after %0d edges, need 1 after 3", tag, out_valid,
               edges);
      in_valid = 1'b0;
      return;
    end
    n = 0;
    stalls = 0;
    guard = 0;
    while (n < 4 && guard < 200) begin
      got = {out_valid, in_ready, out_idx, out_last, out_re, out_im};
      exp = {1'b1, 1'b0, 2'(n), (n == 3), 6'(yr[n]), 6'(yi[n])};
      nchk++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL %s out n=%0d: {v,rdy,idx,last,re,im} got %b_%b_%0d_%b_%0d_%0d need %b_%b_%0d_%b_%0d_%0d",
                 tag, n, got[16], got[15], got[14:13], got[12], $signed(got[11:6]),
                 $signed(got[5:0]), exp[16], exp[15], exp[14:13], exp[12], $signed(exp[11:6]),
                 $signed(exp[5:0]));
      end
      if (n == stall_n && stalls < 5) begin
        out_ready = 1'b0;
        in_valid = 1'b1;
        stalls++;
      end else begin
        out_ready = (int'($urandom_range(99)) < rprob) || (guard > 20);
        in_valid = 1'($urandom_range(1));
      end
      in_re = 4'($urandom);
      in_im = 4'($urandom);
      @(negedge clk);
      if (out_ready) begin n++; guard = 0; end else guard++;
    end
    in_valid = 1'b0;
    nchk++;
    if (n != 4 || {in_ready, out_valid, out_last} !== 3'b100) begin
      nerr++;
      $display("FAIL %s frame end: n=%0d rdy/valid/last got %b need 4 100", tag, n,
               {in_ready, out_valid, out_last});
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if ({in_ready, out_valid, out_last, out_idx, out_re, out_im} !== {3'b100, 2'd0, 12'd0}) begin
      nerr++;
      $display("FAIL reset state: rdy/val/last/idx/re/im got %b/%b/%b/%0d/%0d/%0d need 1/0/0/0/0/0",
               in_ready, out_valid, out_last, out_idx, out_re, out_im);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_impulse();
    int re[4];
    int im[4];
    re = '{4, 0, 0, 0};
    im = '{0, 0, 0, 0};
    run_frame(re, im, 100, 100, -1, "impulse");
  endtask

  task automatic test_shift();
    int re[4];
    int im[4];
    re = '{0, 1, 0, 0};
    im = '{0, 0, 0, 0};
    run_frame(re, im, 100, 100, -1, "shift");
  endtask

  task automatic test_extremes();
    int re[4];
    int im[4];
    re = '{-8, -8, -8, -8};
    im = '{-8, -8, -8, -8};
    run_frame(re, im, 100, 100, -1, "all_neg8");
    re = '{7, 7, 7, 7};
    im = '{7, 7, 7, 7};
    run_frame(re, im, 100, 100, -1, "all_pos7");
  endtask

  task automatic test_mixed();
    int re[4];
    int im[4];
    re = '{7, -8, -8, 7};
    im = '{0, 0, 0, 0};
    run_frame(re, im, 100, 100, -1, "mixed");
  endtask

  task automatic test_backpressure();
    int re[4];
    int im[4];
    re = '{3, -2, 5, -7};
    im = '{-1, 6, -8, 2};
    run_frame(re, im, 100, 100, 1, "backpressure");
    re = '{-5, 1, 0, 4};
    im = '{2, -3, 7, -6};
    run_frame(re, im, 100, 100, -1, "after_bp");
  endtask

  task automatic test_reset_midframe();
    int re[4];
    int im[4];
    logic signed [3:0] junk[4];
    junk = '{4'sd3, -4'sd5, 4'sd6, -4'sd2};
    re = '{4, 0, 0, 0};
    im = '{0, 0, 0, 0};
    // Mid-load abort after two bins.
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_re = junk[k];
      in_im = junk[k + 2];
      @(negedge clk);
    end
    test_reset();
    run_frame(re, im, 100, 100, -1, "reset_midload");
    // Mid-compute abort right after the fourth bin.
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_re = junk[k];
      in_im = junk[3 - k];
      @(negedge clk);
    end
    test_reset();
    run_frame(re, im, 70, 100, -1, "reset_midcompute");
  endtask

  task automatic test_soak();
    int re[4];
    int im[4];
    for (int f = 0; f < 1000; f++) begin
      for (int k = 0; k < 4; k++) begin
        re[k] = int'($urandom_range(15)) - 8;
        im[k] = int'($urandom_range(15)) - 8;
      end
      run_frame(re, im, 30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)), -1,
                "soak");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_re = '0;
    in_im = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_impulse();
    test_shift();
    test_extremes();
    test_mixed();
    test_backpressure();
    test_reset_midframe();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
